// File: rtl/divroot_pkg.sv
// Shared widths, mode encodings, FSM states and request operand layout for the
// division/n-th-root request sequencer.
package divroot_pkg;

   localparam int DATA1_W = 10;
   localparam int DATA2_W = 3;
   localparam int RES_W   = 20;

   localparam logic MODE_DIV  = 1'b0;
   localparam logic MODE_ROOT = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_e;

   // Operand part of a request; the top appends its parameterised tag.
   typedef struct packed {
      logic               mode;
      logic [DATA1_W-1:0] data_1;
      logic [DATA2_W-1:0] data_2;
   } req_op_t;

endpackage

// File: rtl/divroot_req_fifo.sv
// Synchronous request FIFO with full/empty flags; push and pop may coincide.
module divroot_req_fifo #(
   parameter int  DEPTH = 4,
   parameter type req_t = logic
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  req_t wdata,
   input  logic pop,
   output req_t rdata,
   output logic full,
   output logic empty
);

   localparam int PTR_W = $clog2(DEPTH);

   req_t             mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             do_push, do_pop;

   assign full    = (count_q == (PTR_W+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q];

   // NOTE: storage is deliberately not reset; count_q alone says which slots hold data.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
      end
   end

endmodule

// File: rtl/divroot_dispatch.sv
// Sequences queued divide/root requests into the core one at a time and returns
// tagged results. Define DIVROOT_TIMEOUT_EN to bound the wait for a core result.
module divroot_dispatch
   import divroot_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 2,
   parameter int TIMEOUT = 1000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_mode,
   input  logic [DATA1_W-1:0] req_data_1,
   input  logic [DATA2_W-1:0] req_data_2,
   input  logic [TAG_W-1:0]   req_tag,
   output logic               core_in_valid,
   output logic               core_in_mode,
   output logic [DATA1_W-1:0] core_in_data_1,
   output logic [DATA2_W-1:0] core_in_data_2,
   input  logic               core_out_valid,
   input  logic [RES_W-1:0]   core_out_data,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [RES_W-1:0]   rsp_data,
   output logic [TAG_W-1:0]   rsp_tag,
   output logic               rsp_err
);

   typedef struct packed {
      req_op_t          op;
      logic [TAG_W-1:0] tag;
   } req_t;

   state_e           state_q;
   req_t             push_req, head;
   logic             fifo_full, fifo_empty, pop;
   req_op_t          core_in_op_q;
   logic             core_in_valid_q, rsp_valid_q, rsp_err_q;
   logic [RES_W-1:0] rsp_data_q;
   logic [TAG_W-1:0] rsp_tag_q;

`ifdef DIVROOT_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] wait_cnt_q;
`endif

   assign push_req = '{op: '{mode: req_mode, data_1: req_data_1, data_2: req_data_2}, tag: req_tag};
   assign pop       = (state_q == ST_IDLE) && !fifo_empty;
   assign req_ready = !fifo_full;

   divroot_req_fifo #(
      .DEPTH (DEPTH),
      .req_t (req_t)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (req_valid),
      .wdata (push_req),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // NOTE: every state and output register updates with <= so all of them see the pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         core_in_valid_q <= 1'b0;
         core_in_op_q    <= '0;
         rsp_valid_q     <= 1'b0;
         rsp_data_q      <= '0;
         rsp_tag_q       <= '0;
         rsp_err_q       <= 1'b0;
`ifdef DIVROOT_TIMEOUT_EN
         wait_cnt_q      <= '0;
`endif
      end else begin
         core_in_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  rsp_tag_q <= head.tag;
                  if (head.op.data_2 != '0) begin
                     core_in_op_q    <= head.op;
                     core_in_valid_q <= 1'b1;
                     state_q         <= ST_ISSUE;
                  end else begin
                     // Zero divisor/index is answered locally with an error.
                     rsp_data_q  <= '0;
                     rsp_err_q   <= 1'b1;
                     rsp_valid_q <= 1'b1;
                     state_q     <= ST_RESP;
                  end
               end
            end
            ST_ISSUE: begin
               state_q <= ST_WAIT;
`ifdef DIVROOT_TIMEOUT_EN
               wait_cnt_q <= '0;
`endif
            end
            ST_WAIT: begin
               if (core_out_valid) begin
                  rsp_data_q  <= core_out_data;
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_RESP;
               end
`ifdef DIVROOT_TIMEOUT_EN
               else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  rsp_data_q  <= '0;
                  rsp_err_q   <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_RESP;
               end else begin
                  wait_cnt_q <= wait_cnt_q + CNT_W'(1);
               end
`endif
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign core_in_valid  = core_in_valid_q;
   assign core_in_mode   = core_in_op_q.mode;
   assign core_in_data_1 = core_in_op_q.data_1;
   assign core_in_data_2 = core_in_op_q.data_2;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_data       = rsp_data_q;
   assign rsp_tag        = rsp_tag_q;
   assign rsp_err        = rsp_err_q;

endmodule

// File: tb/tb_divroot_dispatch.sv
// Bench for divroot_dispatch: core stub, request-order reference model with an
// every-cycle response/issue checker, and directed scenarios with literal results.
module tb_divroot_dispatch;
   import divroot_pkg::*;

   localparam int DEPTH = 4;
   localparam int TAG_W = 2;
`ifdef DIVROOT_TIMEOUT_EN
   localparam int TIMEOUT = 16;
`else
   localparam int TIMEOUT = 1000;
`endif

   logic        clk, rst;
   logic        req_valid, req_ready, req_mode;
   logic [9:0]  req_data_1;
   logic [2:0]  req_data_2;
   logic [1:0]  req_tag;
   logic        core_in_valid, core_in_mode;
   logic [9:0]  core_in_data_1;
   logic [2:0]  core_in_data_2;
   logic        core_out_valid;
   logic [19:0] core_out_data;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [19:0] rsp_data;
   logic [1:0]  rsp_tag;

   divroot_dispatch #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
      .req_data_1(req_data_1), .req_data_2(req_data_2), .req_tag(req_tag),
      .core_in_valid(core_in_valid), .core_in_mode(core_in_mode),
      .core_in_data_1(core_in_data_1), .core_in_data_2(core_in_data_2),
      .core_out_valid(core_out_valid), .core_out_data(core_out_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_tag(rsp_tag), .rsp_err(rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0, n_fail = 0;
   int rsp_count = 0, issue_count = 0;
   int core_lat = 3;
   bit core_silent = 1'b0;
   int stray_req = 0, stray_done = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference core arithmetic: floor of d1/d2 or d1^(1/d2), scaled by 2^10.
   function automatic logic [19:0] core_result(input logic mode, input logic [9:0] d1, input logic [2:0] d2);
      logic [159:0] lim, pw;
      logic [19:0]  r, cand;
      if (d2 == 3'd0) return '0;
      if (mode == MODE_DIV) return 20'((32'(d1) << 10) / 32'(d2));
      lim = 160'(d1);
      for (int k = 0; k < int'(d2); k++) lim = lim << 10;
      r = '0;
      for (int b = 19; b >= 0; b--) begin
         cand = r | (20'd1 << b);
         pw   = 160'd1;
         for (int k = 0; k < int'(d2); k++) pw = pw * 160'(cand);
         if (pw <= lim) r = cand;
      end
      return r;
   endfunction

   typedef struct {
      logic       mode;
      logic [9:0] d1;
      logic [2:0] d2;
      logic [1:0] tag;
      bit         issued;
      bit         timed_out;
   } exp_t;
   exp_t exp_q[$];

   // Core stub: answers each issue after core_lat cycles; can also fire a stray strobe.
   initial begin
      logic       m;
      logic [9:0] a;
      logic [2:0] n;
      core_out_valid = 1'b0;
      core_out_data  = '0;
      forever begin
         @(negedge clk);
         if (stray_req != stray_done) begin
            @(posedge clk); #1;
            core_out_valid = 1'b1;
            core_out_data  = 20'hABCDE;
            @(posedge clk); #1;
            core_out_valid = 1'b0;
            core_out_data  = '0;
            stray_done = stray_req;
         end else if (core_in_valid && !core_silent && !rst) begin
            m = core_in_mode; a = core_in_data_1; n = core_in_data_2;
            repeat (core_lat) @(posedge clk);
            #1;
            core_out_valid = 1'b1;
            core_out_data  = core_result(m, a, n);
            @(posedge clk); #1;
            core_out_valid = 1'b0;
            core_out_data  = '0;
         end
      end
   end

   // Every-cycle checker against the in-order request model.
   initial begin
      bit          hold_prev = 1'b0;
      logic [19:0] prev_data, exp_data;
      logic [1:0]  prev_tag;
      logic        prev_err, exp_err;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            hold_prev = 1'b0;
         end else begin
            if (req_valid && req_ready)
               exp_q.push_back('{req_mode, req_data_1, req_data_2, req_tag, 1'b0, 1'b0});
            if (core_in_valid) begin
               issue_count++;
               if (exp_q.size() == 0) check("issue_unexpected", 1, 0);
               else begin
                  check("issue_once", 32'(exp_q[0].issued), 0);
                  check("issue_while_rsp", 32'(rsp_valid), 0);
                  check("issue_operands", {core_in_mode, core_in_data_1, core_in_data_2},
                        {exp_q[0].mode, exp_q[0].d1, exp_q[0].d2});
                  exp_q[0].issued    = 1'b1;
                  exp_q[0].timed_out = core_silent;
               end
            end
            if (rsp_valid) begin
               if (hold_prev) begin
                  check("rsp_hold_stable", {rsp_data, rsp_tag, rsp_err}, {prev_data, prev_tag, prev_err});
               end
               if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
               else if (rsp_ready) begin
                  exp_err  = (exp_q[0].d2 == 3'd0) || exp_q[0].timed_out;
                  exp_data = exp_err ? 20'd0 : core_result(exp_q[0].mode, exp_q[0].d1, exp_q[0].d2);
                  check("rsp_data", rsp_data, exp_data);
                  check("rsp_tag", rsp_tag, exp_q[0].tag);
                  check("rsp_err", rsp_err, exp_err);
                  check("rsp_core_used", 32'(exp_q[0].issued), 32'(exp_q[0].d2 != 3'd0));
                  void'(exp_q.pop_front());
                  rsp_count++;
               end
            end
            hold_prev = rsp_valid && !rsp_ready;
            prev_data = rsp_data; prev_tag = rsp_tag; prev_err = rsp_err;
         end
      end
   end

   task automatic sync();
      @(posedge clk); #1;
   endtask

   // Called at posedge+#1; returns at posedge+#1 just after the accepting edge.
   task automatic send(input logic m, input logic [9:0] d1, input logic [2:0] d2, input logic [1:0] tg);
      bit ok = 1'b0;
      req_valid = 1'b1; req_mode = m; req_data_1 = d1; req_data_2 = d2; req_tag = tg;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (req_ready) begin ok = 1'b1; break; end
      end
      if (!ok) check("send_ready_timeout", 0, 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (rsp_valid) begin ok = 1'b1; break; end
      end
      if (!ok) check(name, 0, 1);
   endtask

   task automatic wait_count(input int target, input string name);
      for (int i = 0; i < 1000 && rsp_count < target; i++) @(negedge clk);
      check(name, rsp_count, target);
   endtask

   task automatic check_reset(input string name);
      check({name, "_req_ready"}, req_ready, 1);
      check({name, "_core_in_valid"}, core_in_valid, 0);
      check({name, "_core_in_ops"}, {core_in_mode, core_in_data_1, core_in_data_2}, 0);
      check({name, "_rsp_valid"}, rsp_valid, 0);
      check({name, "_rsp_data"}, rsp_data, 0);
      check({name, "_rsp_tag"}, rsp_tag, 0);
      check({name, "_rsp_err"}, rsp_err, 0);
   endtask

   initial begin
      int base, iss;
      bit seen;
      rst = 1'b1; req_valid = 1'b0; req_mode = 1'b0; req_data_1 = '0; req_data_2 = '0;
      req_tag = '0; rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset("reset");

      // Pin the reference arithmetic with hand-computed values.
      check("model_div_100_4", core_result(MODE_DIV, 10'd100, 3'd4), 20'h06400);
      check("model_root_8_3", core_result(MODE_ROOT, 10'd8, 3'd3), 20'h00800);
      check("model_div_999_7", core_result(MODE_DIV, 10'd999, 3'd7), 20'h23ADB);
      check("model_root_1000_2", core_result(MODE_ROOT, 10'd1000, 3'd2), 20'h07E7D);

      // Core strobe while idle must not produce a response.
      stray_req++;
      repeat (5) begin
         @(negedge clk);
         check("stray_ignored", rsp_valid, 0);
      end

      // Divide 100 / 4, tag 1: issue exactly two cycles after acceptance.
      core_lat = 3;
      sync();
      send(MODE_DIV, 10'd100, 3'd4, 2'd1);
      @(negedge clk); check("t1_no_issue_n1", core_in_valid, 0);
      @(negedge clk); check("t1_issue_n2", core_in_valid, 1);
      check("t1_operands", {core_in_mode, core_in_data_1, core_in_data_2}, {1'b0, 10'd100, 3'd4});
      @(negedge clk); check("t1_single_pulse", core_in_valid, 0);
      wait_rsp("t1_rsp_timeout");
      check("t1_data", rsp_data, 20'h06400);
      check("t1_tag", rsp_tag, 1);
      check("t1_err", rsp_err, 0);

      // Root 8, n=3: response exactly one cycle after the core strobe.
      core_lat = 5;
      sync();
      send(MODE_ROOT, 10'd8, 3'd3, 2'd3);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (core_out_valid) begin seen = 1'b1; break; end
      end
      check("t2_core_strobe_seen", seen, 1);
      check("t2_rsp_not_yet", rsp_valid, 0);
      @(negedge clk);
      check("t2_rsp_m_plus_1", rsp_valid, 1);
      check("t2_data", rsp_data, 20'h00800);
      check("t2_err", rsp_err, 0);

      // Zero divisor: rejected locally, response two cycles after acceptance.
      sync();
      iss = issue_count;
      send(MODE_DIV, 10'd55, 3'd0, 2'd2);
      @(negedge clk); check("t3_rsp_not_yet", rsp_valid, 0);
      @(negedge clk); check("t3_rsp_n2", rsp_valid, 1);
      check("t3_data", rsp_data, 0);
      check("t3_err", rsp_err, 1);
      check("t3_tag", rsp_tag, 2);
      check("t3_no_issue", issue_count, iss);

      // Five back-to-back requests with a slow core: FIFO fills, order kept.
      core_lat = 10;
      base = rsp_count;
      iss  = issue_count;
      sync();
      for (int i = 0; i < 5; i++)
         send(1'(i % 2), 10'(200 + i * 100), 3'(i + 1), 2'(i));
      @(negedge clk);
      check("t4_full_ready_low", req_ready, 0);
      wait_count(base + 5, "t4_rsp_count");
      check("t4_issue_count", issue_count - iss, 5);

      // Consumer stalls for 20 cycles: response held, no further issue.
      core_lat = 2;
      sync();
      rsp_ready = 1'b0;
      base = rsp_count;
      send(MODE_DIV, 10'd999, 3'd7, 2'd1);
      send(MODE_ROOT, 10'd1000, 3'd2, 2'd2);
      wait_rsp("t5_rsp_timeout");
      iss = issue_count;
      check("t5_data", rsp_data, 20'h23ADB);
      repeat (20) begin
         @(negedge clk);
         check("t5_hold_valid", rsp_valid, 1);
      end
      check("t5_no_issue_while_held", issue_count, iss);
      sync();
      rsp_ready = 1'b1;
      wait_count(base + 2, "t5_rsp_count");

      // Reset while the core is busy: everything back to reset values next cycle.
      core_silent = 1'b1;
      sync();
      send(MODE_ROOT, 10'd500, 3'd5, 2'd3);
      repeat (5) @(negedge clk);
      sync();
      rst = 1'b1;
      sync();
      rst = 1'b0;
      @(negedge clk);
      check_reset("midrst");
      core_silent = 1'b0;
      core_lat = 1;
      sync();
      send(MODE_DIV, 10'd10, 3'd1, 2'd0);
      wait_rsp("t6_recover_timeout");
      check("t6_recover_data", rsp_data, 20'h02800);

`ifdef DIVROOT_TIMEOUT_EN
      // Silent core: timeout after exactly TIMEOUT wait cycles.
      begin
         int n = 0;
         core_silent = 1'b1;
         sync();
         send(MODE_DIV, 10'd300, 3'd3, 2'd1);
         for (int i = 0; i < 20 && !core_in_valid; i++) @(negedge clk);
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (rsp_valid) break;
         end
         check("t7_timeout_latency", n, TIMEOUT + 1);
         check("t7_data", rsp_data, 0);
         check("t7_err", rsp_err, 1);
         sync();
         core_silent = 1'b0;
      end
`endif

      repeat (5) @(negedge clk);
      check("final_model_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
